config_tile_receiver: RTL

CONFIG_TILE_RECEIVER -- requirements
Module: config_tile_receiver

---
 rtl/config_tile_receiver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/config_tile_receiver.sv
// Config tile receiver: two-stage pipelined decode of a shared config bus into a
// small bank of 32-bit registers, with readback, a sticky bad-index flag and a
// load-complete detector driven by bus idle time.
module config_tile_receiver #(
  parameter logic [15:0] TILE_ID    = 16'h0015,
  parameter logic [7:0]  FEATURE_ID = 8'h00,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DONE_IDLE  = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_read_in,
  output logic [32*NUM_REGS-1:0]   config_regs_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out,
  output logic                     err_out,
  output logic                     done_out
);

  typedef enum logic [1:0] {StEmpty, StLoading, StDone} state_e;

  localparam logic [3:0] DoneIdle = 4'(DONE_IDLE);

  // Stage-1 pipeline registers
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_read;

  // Architectural state
  logic [NUM_REGS-1:0][31:0] r_regs;
  logic [31:0]               r_read_data;
  logic                      r_read_valid;
  logic                      r_err;
  logic                      r_done;
  state_e                    r_state;
  logic [3:0]                r_idle_cnt;

  // Stage-2 decode
  logic        w_hit;
  logic [7:0]  w_idx;
  logic        w_in_range;
  logic        w_wr;
  logic        w_rd;
  logic        w_bad;
  logic        w_idle;
  logic [31:0] w_rd_word;
  state_e      w_state_next;
  logic [3:0]  w_idle_next;

  // Stage 1: capture the bus every cycle, unconditionally
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_addr <= '0;
      r_data <= '0;
      r_read <= 1'b0;
    end else begin
      r_addr <= config_addr_in;
      r_data <= config_data_in;
      r_read <= config_read_in;
    end
  end

  // Stage-2 address decode and classification of the registered operation
  always_comb begin
    w_idle     = (r_addr == '0);
    w_hit      = !w_idle && (r_addr[15:0] == TILE_ID) && (r_addr[23:16] == FEATURE_ID);
    w_idx      = r_addr[31:24];
    w_in_range = ({24'd0, w_idx} < NUM_REGS);
    w_wr       = w_hit && !r_read && w_in_range;
    w_rd       = w_hit && r_read && w_in_range;
    w_bad      = w_hit && !w_in_range;
  end

  // Readback mux; compares against constant indices so no out-of-range select exists
  always_comb begin
    w_rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_idx == 8'(r)) begin
        w_rd_word = r_regs[r];
      end
    end
  end

  // Config register bank: accepted writes land at the stage-2 edge
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_regs <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wr && (w_idx == 8'(r))) begin
          r_regs[r] <= r_data;
        end
      end
    end
  end

  // Read strobe, held readback data and sticky error flag
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_read_valid <= w_rd;
      if (w_rd) begin
        r_read_data <= w_rd_word;
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Load FSM next state: idle counting only while LOADING, saturating at 15
  always_comb begin
    w_state_next = r_state;
    w_idle_next  = r_idle_cnt;
    case (r_state)
      StEmpty: begin
        if (w_wr) begin
          w_state_next = StLoading;
          w_idle_next  = '0;
        end
      end
      StLoading: begin
        if (w_idle) begin
          if (r_idle_cnt != 4'hF) begin
            w_idle_next = r_idle_cnt + 4'd1;
          end
          if (w_idle_next >= DoneIdle) begin
            w_state_next = StDone;
          end
        end else begin
          w_idle_next = '0;
        end
      end
      StDone: begin
        if (w_wr) begin
          w_state_next = StLoading;
          w_idle_next  = '0;
        end
      end
      default: begin
        w_state_next = StEmpty;
        w_idle_next  = '0;
      end
    endcase
  end

  // Load FSM state, idle counter and registered done flag
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state    <= StEmpty;
      r_idle_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idle_cnt <= w_idle_next;
      r_done     <= (w_state_next == StDone);
    end
  end

  assign config_regs_out = r_regs;
  assign read_data_out   = r_read_data;
  assign read_valid_out  = r_read_valid;
  assign err_out         = r_err;
  assign done_out        = r_done;

endmodule
